jtag_master: RTL

JTAG_MASTER -- requirements
Module: jtag_master

---
 rtl/jtag_master.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG TAP master.
// A command (RESET, IR scan, DR scan, IDLE clocks) is accepted from a
// valid/ready handshake, played out on TCK/TMS/TDI with a programmable
// TCK half-period, and completed with a one-cycle response pulse that
// carries the captured TDO bits.
//
// Handshake: a command transfers on the rising clk_i edge where both
// cmd_valid_i and cmd_ready_o are high. cmd_ready_o is high only while
// idle, and cmd_valid_i has no effect while cmd_ready_o is low (no queue).
// rsp_valid_o is a single-cycle pulse with no back-pressure; rsp_data_o
// and rsp_err_o stay stable until the next pulse.
`timescale 1ns/1ps
module jtag_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_type_i,
  input  logic [6:0]  cmd_len_i,
  input  logic [63:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE_ST  = 3'd0,
    PRE_ST   = 3'd1,
    SHIFT_ST = 3'd2,
    POST_ST  = 3'd3,
    DONE_ST  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RESET = 2'd0;
  localparam logic [1:0] CMD_IR    = 2'd1;
  localparam logic [1:0] CMD_DR    = 2'd2;
  localparam logic [1:0] CMD_IDLE  = 2'd3;

  // Last count value of a TCK phase; the divider reloads to 0 after it.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // Number of TCKs spent in a segment (entry sequence, shift, exit sequence).
  function automatic logic [6:0] seg_len(input state_t s, input logic [1:0] t,
                                         input logic [6:0] n);
    logic [6:0] len;
    len = 7'd0;
    case (s)
      PRE_ST: begin
        case (t)
          CMD_RESET: len = 7'd6;
          CMD_IR:    len = 7'd4;
          CMD_DR:    len = 7'd3;
          default:   len = 7'd0;
        endcase
      end
      SHIFT_ST: len = n;
      POST_ST:  len = 7'd2;
      default:  len = 7'd0;
    endcase
    return len;
  endfunction

  // TMS value for TCK number i of a segment.
  function automatic logic seg_tms(input state_t s, input logic [1:0] t,
                                   input logic [6:0] n, input logic [6:0] i);
    logic tms;
    tms = 1'b0;
    case (s)
      PRE_ST: begin
        case (t)
          CMD_RESET: tms = (i < 7'd5);
          CMD_IR:    tms = (i < 7'd2);
          CMD_DR:    tms = (i == 7'd0);
          default:   tms = 1'b0;
        endcase
      end
      SHIFT_ST: tms = ((t == CMD_IR) || (t == CMD_DR)) && (i == n - 7'd1);
      POST_ST:  tms = (i == 7'd0);
      default:  tms = 1'b0;
    endcase
    return tms;
  endfunction

  // TDI value for TCK number i of a segment; idles high outside scan shifts.
  function automatic logic seg_tdi(input state_t s, input logic [1:0] t,
                                   input logic [6:0] i, input logic [63:0] d);
    logic tdi;
    tdi = 1'b1;
    if ((s == SHIFT_ST) && ((t == CMD_IR) || (t == CMD_DR))) begin
      tdi = d[i[5:0]];
    end
    return tdi;
  endfunction

  state_t      r_state;
  logic [1:0]  r_type;
  logic [6:0]  r_len;
  logic [63:0] r_data;
  logic [63:0] r_cap;
  logic [7:0]  r_div;
  logic [6:0]  r_idx;
  logic        r_tck;
  logic        r_tms;
  logic        r_tdi;
  logic [63:0] r_rsp_data;
  logic        r_rsp_err;

  state_t      w_state_nxt;
  state_t      w_first_st;
  logic        w_cmd_bad;
  logic        w_scan;
  logic        w_active;
  logic        w_phase_end;
  logic        w_tck_end;
  logic [6:0]  w_seg_len;
  logic        w_seg_last;
  logic [6:0]  w_idx_nxt;

  assign w_cmd_bad   = (cmd_type_i != CMD_RESET) &&
                       ((cmd_len_i == 7'd0) || (cmd_len_i > 7'd64));
  assign w_first_st  = (cmd_type_i == CMD_IDLE) ? SHIFT_ST : PRE_ST;
  assign w_scan      = (r_type == CMD_IR) || (r_type == CMD_DR);
  assign w_active    = (r_state == PRE_ST) || (r_state == SHIFT_ST) ||
                       (r_state == POST_ST);
  assign w_phase_end = w_active && (r_div == DIV_LAST);
  assign w_tck_end   = w_phase_end && r_tck;
  assign w_seg_len   = seg_len(r_state, r_type, r_len);
  assign w_seg_last  = (r_idx == w_seg_len - 7'd1);
  assign w_idx_nxt   = w_seg_last ? 7'd0 : r_idx + 7'd1;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE_ST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: segments advance only when a full TCK period has ended.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE_ST: begin
        if (cmd_valid_i) begin
          w_state_nxt = w_cmd_bad ? DONE_ST : w_first_st;
        end
      end
      PRE_ST: begin
        if (w_tck_end && w_seg_last) begin
          w_state_nxt = (r_type == CMD_RESET) ? DONE_ST : SHIFT_ST;
        end
      end
      SHIFT_ST: begin
        if (w_tck_end && w_seg_last) begin
          w_state_nxt = w_scan ? POST_ST : DONE_ST;
        end
      end
      POST_ST: begin
        if (w_tck_end && w_seg_last) begin
          w_state_nxt = DONE_ST;
        end
      end
      DONE_ST: w_state_nxt = IDLE_ST;
      default: w_state_nxt = IDLE_ST;
    endcase
  end

  // Datapath: command capture, TCK divider, pin updates, TDO capture, response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_type     <= 2'd0;
      r_len      <= 7'd0;
      r_data     <= 64'd0;
      r_cap      <= 64'd0;
      r_div      <= 8'd0;
      r_idx      <= 7'd0;
      r_tck      <= 1'b0;
      r_tms      <= 1'b1;
      r_tdi      <= 1'b1;
      r_rsp_data <= 64'd0;
      r_rsp_err  <= 1'b0;
    end else if ((r_state == IDLE_ST) && cmd_valid_i) begin
      r_type <= cmd_type_i;
      r_len  <= cmd_len_i;
      r_data <= cmd_data_i;
      r_cap  <= 64'd0;
      r_div  <= 8'd0;
      r_idx  <= 7'd0;
      r_tck  <= 1'b0;
      if (w_cmd_bad) begin
        r_rsp_data <= 64'd0;
        r_rsp_err  <= 1'b1;
      end else begin
        // First TCK low phase starts right away, so its pins are set now.
        r_tms <= seg_tms(w_first_st, cmd_type_i, cmd_len_i, 7'd0);
        r_tdi <= seg_tdi(w_first_st, cmd_type_i, 7'd0, cmd_data_i);
      end
    end else if (w_active) begin
      if (w_phase_end) begin
        r_div <= 8'd0;
        r_tck <= ~r_tck;
        // TDO is taken on the edge that raises TCK.
        if (!r_tck && (r_state == SHIFT_ST) && w_scan) begin
          r_cap[r_idx[5:0]] <= tdo_i;
        end
        if (r_tck) begin
          r_idx <= w_idx_nxt;
          r_tms <= seg_tms(w_state_nxt, r_type, r_len, w_idx_nxt);
          r_tdi <= seg_tdi(w_state_nxt, r_type, w_idx_nxt, r_data);
          if (w_state_nxt == DONE_ST) begin
            r_rsp_data <= r_cap;
            r_rsp_err  <= 1'b0;
          end
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  assign cmd_ready_o = (r_state == IDLE_ST);
  assign rsp_valid_o = (r_state == DONE_ST);
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
  assign tck_o       = r_tck;
  assign tms_o       = r_tms;
  assign tdi_o       = r_tdi;
  assign dbg_state_o = r_state;

endmodule
